bitmap_alloc_ctrl: RTL and testbench

- Page-allocation engine that owns and drives a 1-write/2-read synchronous RAM holding a free-page bitmap: 2^ADDR_WIDTH words of DATA_WIDTH bits; bit = 1 means used.
- Accepts ALLOC and FREE requests over a valid/ready handshake. Scans two bitmap words per probe using both RAM read ports, then read-modify-writes the selected word.
- Sits directly upstream of the bitmap RAM and downstream of the MMU request arbiter.

---
 rtl/bitmap_alloc_if.sv | 27 ++
 rtl/bitmap_alloc_ctrl.sv | 173 +++++++++++++++++
 tb/tb_bitmap_alloc_ctrl.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bitmap_alloc_if.sv
// Request/response handshake between the MMU arbiter (master) and the
// bitmap page allocator (slave).
interface bitmap_alloc_if #(
   parameter int ADDR_WIDTH    = 6,
   parameter int BIT_SEL_WIDTH = 6
);
   localparam int IDX_W = ADDR_WIDTH + BIT_SEL_WIDTH;

   logic             req_valid;
   logic             req_ready;
   logic             req_op;
   logic [IDX_W-1:0] req_index;
   logic             resp_valid;
   logic             resp_ready;
   logic [IDX_W-1:0] resp_index;
   logic             resp_fail;

   modport master (
      output req_valid, req_op, req_index, resp_ready,
      input  req_ready, resp_valid, resp_index, resp_fail
   );

   modport slave (
      input  req_valid, req_op, req_index, resp_ready,
      output req_ready, resp_valid, resp_index, resp_fail
   );
endinterface

// File: rtl/bitmap_alloc_ctrl.sv
// Free-page bitmap allocator: clears the RAM after reset, scans two words per
// probe for ALLOC, and read-modify-writes one word per ALLOC/FREE.
module bitmap_alloc_ctrl #(
   parameter int ADDR_WIDTH    = 6,
   parameter int DATA_WIDTH    = 64,
   parameter int BIT_SEL_WIDTH = 6
) (
   input  logic                              clk,
   input  logic                              rst_n,
   bitmap_alloc_if.slave                     bus,
   output logic [ADDR_WIDTH+BIT_SEL_WIDTH:0] free_cnt,
   output logic                              init_done,
   output logic                              ram_write_en,
   output logic [ADDR_WIDTH-1:0]             ram_write_addr,
   output logic [DATA_WIDTH-1:0]             ram_write_data,
   output logic [ADDR_WIDTH-1:0]             ram_read_addr1,
   output logic [ADDR_WIDTH-1:0]             ram_read_addr2,
   input  logic [DATA_WIDTH-1:0]             ram_read_data1,
   input  logic [DATA_WIDTH-1:0]             ram_read_data2
);
   localparam int IDX_W = ADDR_WIDTH + BIT_SEL_WIDTH;
   localparam int PW    = (ADDR_WIDTH > 1) ? ADDR_WIDTH - 1 : 1;
   localparam logic [PW-1:0]    P_LAST   = PW'((1 << (ADDR_WIDTH - 1)) - 1);
   localparam logic [IDX_W:0]   FULL_CNT = {1'b1, {IDX_W{1'b0}}};
   localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1);

   typedef enum logic [2:0] {
      S_INIT, S_IDLE, S_SCAN_RD, S_SCAN_CHK, S_FREE_RD, S_FREE_CHK, S_WRITE, S_RESP
   } state_t;

   state_t                  r_state, w_state_nxt;
   logic [ADDR_WIDTH-1:0]   r_init_addr;
   logic [PW-1:0]           r_pair;
   logic [IDX_W:0]          r_free_cnt;
   logic                    r_init_done;
   logic [IDX_W-1:0]        r_resp_index;
   logic                    r_resp_fail;
   logic                    r_is_free;
   logic [ADDR_WIDTH-1:0]   r_wr_addr;
   logic [DATA_WIDTH-1:0]   r_wr_data;

   logic                    w_hit1, w_hit2, w_last_pair, w_freed_bit;
   logic [ADDR_WIDTH-1:0]   w_addr_even, w_addr_odd, w_sel_word, w_free_word;
   logic [DATA_WIDTH-1:0]   w_sel_data;
   logic [BIT_SEL_WIDTH-1:0] w_sel_bit, w_free_bit;

   function automatic logic [BIT_SEL_WIDTH-1:0] f_low_zero(input logic [DATA_WIDTH-1:0] d);
      f_low_zero = '0;
      for (int i = DATA_WIDTH - 1; i >= 0; i--)
         if (!d[i]) f_low_zero = BIT_SEL_WIDTH'(i);
   endfunction

   // Cast drops the pair-LSB padding when the RAM has a single pair.
   assign w_addr_even = ADDR_WIDTH'({r_pair, 1'b0});
   assign w_addr_odd  = ADDR_WIDTH'({r_pair, 1'b1});
   assign w_hit1      = ~&ram_read_data1;
   assign w_hit2      = ~&ram_read_data2;
   assign w_last_pair = (r_pair == P_LAST);
   assign w_sel_data  = w_hit1 ? ram_read_data1 : ram_read_data2;
   assign w_sel_word  = w_hit1 ? w_addr_even : w_addr_odd;
   assign w_sel_bit   = f_low_zero(w_sel_data);
   assign w_free_word = r_resp_index[IDX_W-1:BIT_SEL_WIDTH];
   assign w_free_bit  = r_resp_index[BIT_SEL_WIDTH-1:0];
   assign w_freed_bit = ram_read_data1[w_free_bit];

   assign bus.resp_valid = (r_state == S_RESP);
   assign bus.resp_index = r_resp_index;
   assign bus.resp_fail  = r_resp_fail;
   assign free_cnt       = r_free_cnt;
   assign init_done      = r_init_done;

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= S_INIT;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt    = r_state;
      bus.req_ready  = 1'b0;
      ram_write_en   = 1'b0;
      ram_write_addr = '0;
      ram_write_data = '0;
      ram_read_addr1 = '0;
      ram_read_addr2 = '0;
      case (r_state)
         S_INIT: begin
            ram_write_en   = 1'b1;
            ram_write_addr = r_init_addr;
            if (&r_init_addr) w_state_nxt = S_IDLE;
         end
         S_IDLE: begin
            bus.req_ready = 1'b1;
            if (bus.req_valid) begin
               if (bus.req_op)             w_state_nxt = S_FREE_RD;
               else if (r_free_cnt == '0)  w_state_nxt = S_RESP;
               else                        w_state_nxt = S_SCAN_RD;
            end
         end
         S_SCAN_RD: begin
            ram_read_addr1 = w_addr_even;
            ram_read_addr2 = w_addr_odd;
            w_state_nxt    = S_SCAN_CHK;
         end
         S_SCAN_CHK: begin
            if (w_hit1 || w_hit2) w_state_nxt = S_WRITE;
            else if (w_last_pair) w_state_nxt = S_RESP;
            else                  w_state_nxt = S_SCAN_RD;
         end
         S_FREE_RD: begin
            ram_read_addr1 = w_free_word;
            w_state_nxt    = S_FREE_CHK;
         end
         S_FREE_CHK: w_state_nxt = w_freed_bit ? S_WRITE : S_RESP;
         S_WRITE: begin
            ram_write_en   = 1'b1;
            ram_write_addr = r_wr_addr;
            ram_write_data = r_wr_data;
            w_state_nxt    = S_RESP;
         end
         S_RESP: if (bus.resp_ready) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_INIT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_init_addr  <= '0;
         r_pair       <= '0;
         r_free_cnt   <= FULL_CNT;
         r_init_done  <= 1'b0;
         r_resp_index <= '0;
         r_resp_fail  <= 1'b0;
         r_is_free    <= 1'b0;
         r_wr_addr    <= '0;
         r_wr_data    <= '0;
      end else begin
         case (r_state)
            S_INIT: begin
               r_init_addr <= r_init_addr + 1'b1;
               if (&r_init_addr) r_init_done <= 1'b1;
            end
            S_IDLE: if (bus.req_valid) begin
               r_is_free    <= bus.req_op;
               r_pair       <= '0;
               r_resp_index <= bus.req_op ? bus.req_index : '0;
               r_resp_fail  <= !bus.req_op && (r_free_cnt == '0);
            end
            S_SCAN_CHK: begin
               if (w_hit1 || w_hit2) begin
                  r_wr_addr    <= w_sel_word;
                  r_wr_data    <= w_sel_data | (ONE << w_sel_bit);
                  r_resp_index <= {w_sel_word, w_sel_bit};
               end else if (w_last_pair) begin
                  r_resp_fail  <= 1'b1;
               end else begin
                  r_pair       <= r_pair + 1'b1;
               end
            end
            S_FREE_CHK: begin
               // A clear bit here means the page was never allocated.
               if (!w_freed_bit) r_resp_fail <= 1'b1;
               r_wr_addr <= w_free_word;
               r_wr_data <= ram_read_data1 & ~(ONE << w_free_bit);
            end
            S_WRITE: begin
               if (r_is_free) r_free_cnt <= r_free_cnt + 1'b1;
               else           r_free_cnt <= r_free_cnt - 1'b1;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_bitmap_alloc_ctrl.sv
// Randomized self-checking bench for bitmap_alloc_ctrl against a page-array model.
module tb_bitmap_alloc_ctrl;
   localparam int AW = 6, DW = 16, BW = 4, IW = AW + BW, NP = 1 << IW, NW = 1 << AW;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   bitmap_alloc_if #(.ADDR_WIDTH(AW), .BIT_SEL_WIDTH(BW)) bus ();
   logic [IW:0]   free_cnt;
   logic          init_done, ram_write_en;
   logic [AW-1:0] ram_write_addr, ram_read_addr1, ram_read_addr2;
   logic [DW-1:0] ram_write_data, ram_read_data1, ram_read_data2;

   bitmap_alloc_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BIT_SEL_WIDTH(BW)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus), .free_cnt(free_cnt), .init_done(init_done),
      .ram_write_en(ram_write_en), .ram_write_addr(ram_write_addr), .ram_write_data(ram_write_data),
      .ram_read_addr1(ram_read_addr1), .ram_read_addr2(ram_read_addr2),
      .ram_read_data1(ram_read_data1), .ram_read_data2(ram_read_data2));

   // 1W2R RAM, registered reads, no write-to-read forwarding
   logic [DW-1:0] mem [NW];
   always @(posedge clk) begin
      if (ram_write_en) mem[ram_write_addr] <= ram_write_data;
      ram_read_data1 <= mem[ram_read_addr1];
      ram_read_data2 <= mem[ram_read_addr2];
   end

   int checks = 0, errors = 0;

   // Reference model: one flag per page, lowest free page wins.
   bit used [NP];
   int mfree;

   task automatic model_clear();
      for (int i = 0; i < NP; i++) used[i] = 1'b0;
      mfree = NP;
   endtask

   task automatic model_alloc(output int idx, output bit fail);
      idx = 0; fail = 1'b1;
      for (int i = 0; i < NP; i++)
         if (!used[i]) begin idx = i; fail = 1'b0; break; end
      if (!fail) begin used[idx] = 1'b1; mfree--; end
   endtask

   task automatic model_free(input int idx, output bit fail);
      fail = !used[idx];
      if (!fail) begin used[idx] = 1'b0; mfree++; end
   endtask

   function automatic logic [DW-1:0] model_word(input int w);
      logic [DW-1:0] v;
      for (int b = 0; b < DW; b++) v[b] = used[w*DW + b];
      return v;
   endfunction

   function automatic int alloc_lat(input int idx);
      return 2 * ((idx / DW) / 2) + 4;
   endfunction

   task automatic tick();
      @(posedge clk); #1;
   endtask

   // Observations of the most recent operation
   logic [IW-1:0] ob_idx;
   logic          ob_fail;
   int            ob_lat, ob_nwr, ob_wait;
   logic [AW-1:0] ob_waddr;
   logic [DW-1:0] ob_wdata;
   logic [AW-1:0] ra1_log [8], ra2_log [8];

   task automatic do_op(input bit op, input int idx);
      bus.resp_ready = 1'b1;
      bus.req_op     = op;
      bus.req_index  = IW'(idx);
      bus.req_valid  = 1'b1;
      ob_wait = 0; ob_nwr = 0; ob_lat = 0;
      ob_waddr = '0; ob_wdata = '0;
      for (int i = 0; i < 8; i++) begin ra1_log[i] = '0; ra2_log[i] = '0; end
      while (!bus.req_ready && ob_wait < 200) begin tick(); ob_wait++; end
      do begin
         tick(); ob_lat++;
         bus.req_valid = 1'b0;
         if (ram_write_en) begin ob_nwr++; ob_waddr = ram_write_addr; ob_wdata = ram_write_data; end
         if (ob_lat < 8) begin ra1_log[ob_lat] = ram_read_addr1; ra2_log[ob_lat] = ram_read_addr2; end
      end while (!bus.resp_valid && ob_lat < 300);
      ob_idx  = bus.resp_index;
      ob_fail = bus.resp_fail;
      tick();
   endtask

   // Releases reset and watches INIT; returns write count and out-of-order writes.
   task automatic run_init(output int nwr, output int bad);
      int cyc;
      nwr = 0; bad = 0; cyc = 0;
      rst_n = 1'b1;
      while (!init_done && cyc < 200) begin
         if (ram_write_en && ram_write_addr == AW'(nwr) && ram_write_data == '0) nwr++;
         else bad++;
         tick(); cyc++;
      end
      model_clear();
   endtask

   task automatic reinit();
      int n, b;
      rst_n = 1'b0; tick(); tick();
      run_init(n, b);
      checks++;
      if (!init_done) begin errors++; $display("FAIL reinit_timeout: init_done=%0b required 1", init_done); end
   endtask

   task automatic test_reset();
      int n, b;
      bus.req_valid = 1'b0; bus.req_op = 1'b0; bus.req_index = '0; bus.resp_ready = 1'b0;
      rst_n = 1'b0;
      repeat (3) tick();
      checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready: got %0b want 0", bus.req_ready); end
      checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid: got %0b want 0", bus.resp_valid); end
      checks++; if (bus.resp_index !== '0 || bus.resp_fail !== 1'b0) begin errors++; $display("FAIL rst_resp: idx=%0d fail=%0b want 0/0", bus.resp_index, bus.resp_fail); end
      checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL rst_init_done: got %0b want 0", init_done); end
      checks++; if (free_cnt !== (IW+1)'(NP)) begin errors++; $display("FAIL rst_free_cnt: got %0d want %0d", free_cnt, NP); end
      run_init(n, b);
      checks++; if (n != NW || b != 0) begin errors++; $display("FAIL init_writes: got %0d writes %0d bad, want %0d/0", n, b, NW); end
      checks++; if (init_done !== 1'b1 || bus.req_ready !== 1'b1) begin errors++; $display("FAIL init_done: got done=%0b ready=%0b want 1/1", init_done, bus.req_ready); end
      checks++; if (free_cnt !== (IW+1)'(NP)) begin errors++; $display("FAIL init_free_cnt: got %0d want %0d", free_cnt, NP); end
   endtask

   task automatic test_back_to_back();
      int e; bit ef;
      for (int k = 0; k < 3; k++) begin
         model_alloc(e, ef);
         do_op(1'b0, 0);
         checks++; if (ob_idx !== IW'(e) || ob_fail !== 1'b0) begin errors++; $display("FAIL b2b_idx%0d: got %0d/%0b want %0d/0", k, ob_idx, ob_fail, e); end
         checks++; if (ob_lat != alloc_lat(e) || ob_wait != 0) begin errors++; $display("FAIL b2b_lat%0d: got lat %0d wait %0d want %0d/0", k, ob_lat, ob_wait, alloc_lat(e)); end
         checks++; if (ob_nwr != 1 || ob_waddr !== '0 || ob_wdata !== model_word(0)) begin errors++; $display("FAIL b2b_wr%0d: got n=%0d a=%0d d=%0h want 1/0/%0h", k, ob_nwr, ob_waddr, ob_wdata, model_word(0)); end
      end
      checks++; if (free_cnt !== (IW+1)'(mfree)) begin errors++; $display("FAIL b2b_free_cnt: got %0d want %0d", free_cnt, mfree); end
   endtask

   task automatic test_scan_pair();
      int e; bit ef;
      while (mfree > NP - 2*DW) begin
         model_alloc(e, ef);
         do_op(1'b0, 0);
         checks++; if (ob_idx !== IW'(e) || ob_lat != alloc_lat(e)) begin errors++; $display("FAIL fill01: got %0d lat %0d want %0d lat %0d", ob_idx, ob_lat, e, alloc_lat(e)); end
      end
      model_alloc(e, ef);
      do_op(1'b0, 0);
      checks++; if (ob_idx !== IW'(e) || ob_lat != 6) begin errors++; $display("FAIL pair1_hit: got %0d lat %0d want %0d lat 6", ob_idx, ob_lat, e); end
      checks++; if (ra1_log[1] !== AW'(0) || ra2_log[1] !== AW'(1) || ra1_log[3] !== AW'(2) || ra2_log[3] !== AW'(3))
         begin errors++; $display("FAIL pair_reads: got %0d/%0d %0d/%0d want 0/1 2/3", ra1_log[1], ra2_log[1], ra1_log[3], ra2_log[3]); end
   endtask

   task automatic test_free();
      int e; bit ef;
      reinit();
      for (int k = 0; k < 6; k++) begin
         model_alloc(e, ef); do_op(1'b0, 0);
         checks++; if (ob_idx !== IW'(e)) begin errors++; $display("FAIL free_setup: got %0d want %0d", ob_idx, e); end
      end
      model_free(1, ef); do_op(1'b1, 1);
      checks++; if (ob_fail !== ef || ob_idx !== IW'(1) || ob_lat != 4) begin errors++; $display("FAIL free1: got fail=%0b idx=%0d lat=%0d want %0b/1/4", ob_fail, ob_idx, ob_lat, ef); end
      checks++; if (ob_nwr != 1 || ob_waddr !== '0 || ob_wdata !== model_word(0)) begin errors++; $display("FAIL free1_wr: got n=%0d d=%0h want 1/%0h", ob_nwr, ob_wdata, model_word(0)); end
      model_alloc(e, ef); do_op(1'b0, 0);
      checks++; if (ob_idx !== IW'(e)) begin errors++; $display("FAIL realloc: got %0d want %0d", ob_idx, e); end
      model_free(5, ef); do_op(1'b1, 5);
      checks++; if (ob_fail !== ef || ob_lat != 4) begin errors++; $display("FAIL free5: got fail=%0b lat=%0d want %0b/4", ob_fail, ob_lat, ef); end
      model_free(5, ef); do_op(1'b1, 5);
      checks++; if (ob_fail !== 1'b1 || ef !== 1'b1 || ob_lat != 3 || ob_nwr != 0) begin errors++; $display("FAIL dbl_free: got fail=%0b lat=%0d wr=%0d want 1/3/0", ob_fail, ob_lat, ob_nwr); end
      checks++; if (free_cnt !== (IW+1)'(mfree)) begin errors++; $display("FAIL dbl_free_cnt: got %0d want %0d", free_cnt, mfree); end
   endtask

   task automatic test_random();
      int e, idx; bit ef, isf;
      for (int k = 0; k < 150; k++) begin
         isf = ($urandom_range(0, 2) == 0);
         if (isf) begin
            idx = int'($urandom_range(0, 4*DW - 1));
            model_free(idx, ef); do_op(1'b1, idx);
            checks++; if (ob_fail !== ef || ob_idx !== IW'(idx) || ob_lat != (ef ? 3 : 4)) begin errors++; $display("FAIL rnd_free%0d: got fail=%0b idx=%0d lat=%0d want %0b/%0d", k, ob_fail, ob_idx, ob_lat, ef, idx); end
         end else begin
            model_alloc(e, ef); do_op(1'b0, 0);
            checks++; if (ob_fail !== ef || ob_idx !== IW'(e) || ob_lat != alloc_lat(e)) begin errors++; $display("FAIL rnd_alloc%0d: got %0d/%0b lat %0d want %0d/%0b lat %0d", k, ob_idx, ob_fail, ob_lat, e, ef, alloc_lat(e)); end
         end
         checks++; if (free_cnt !== (IW+1)'(mfree)) begin errors++; $display("FAIL rnd_cnt%0d: got %0d want %0d", k, free_cnt, mfree); end
      end
   endtask

   task automatic test_full();
      int e; bit ef;
      while (mfree > 0) begin
         model_alloc(e, ef); do_op(1'b0, 0);
         checks++; if (ob_idx !== IW'(e) || ob_fail !== 1'b0) begin errors++; $display("FAIL fill_all: got %0d/%0b want %0d/0", ob_idx, ob_fail, e); end
      end
      checks++; if (free_cnt !== '0) begin errors++; $display("FAIL full_cnt: got %0d want 0", free_cnt); end
      do_op(1'b0, 0);
      checks++; if (ob_fail !== 1'b1 || ob_idx !== '0 || ob_lat != 1) begin errors++; $display("FAIL full_alloc: got fail=%0b idx=%0d lat=%0d want 1/0/1", ob_fail, ob_idx, ob_lat); end
      checks++; if (ob_nwr != 0 || ra1_log[1] !== '0 || ra2_log[1] !== '0 || free_cnt !== '0) begin errors++; $display("FAIL full_noram: got wr=%0d cnt=%0d want 0/0", ob_nwr, free_cnt); end
   endtask

   task automatic test_stall();
      int e, w; bit ef; logic [IW-1:0] hidx; logic hfail;
      model_free(777, ef); do_op(1'b1, 777);
      checks++; if (ob_fail !== ef || ef !== 1'b0) begin errors++; $display("FAIL stall_prep: got fail=%0b want 0", ob_fail); end
      model_alloc(e, ef);
      bus.resp_ready = 1'b0; bus.req_op = 1'b0; bus.req_valid = 1'b1;
      tick(); bus.req_valid = 1'b0;
      w = 0;
      while (!bus.resp_valid && w < 300) begin tick(); w++; end
      hidx = bus.resp_index; hfail = bus.resp_fail;
      checks++; if (!bus.resp_valid || hidx !== IW'(e) || hfail !== 1'b0) begin errors++; $display("FAIL stall_resp: got v=%0b idx=%0d want 1/%0d", bus.resp_valid, hidx, e); end
      for (int k = 0; k < 5; k++) begin
         tick();
         checks++; if (bus.resp_valid !== 1'b1 || bus.resp_index !== hidx || bus.resp_fail !== hfail || bus.req_ready !== 1'b0)
            begin errors++; $display("FAIL stall_hold%0d: got v=%0b idx=%0d f=%0b rdy=%0b", k, bus.resp_valid, bus.resp_index, bus.resp_fail, bus.req_ready); end
      end
      bus.resp_ready = 1'b1; tick();
      checks++; if (bus.resp_valid !== 1'b0 || free_cnt !== '0) begin errors++; $display("FAIL stall_release: got v=%0b cnt=%0d want 0/0", bus.resp_valid, free_cnt); end
   endtask

   task automatic test_reset_midop();
      int e, n, b; bit ef;
      model_free(3, ef); do_op(1'b1, 3);
      bus.req_op = 1'b0; bus.req_valid = 1'b1;
      tick(); bus.req_valid = 1'b0;
      tick();
      rst_n = 1'b0;
      tick();
      checks++; if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b0 || init_done !== 1'b0) begin errors++; $display("FAIL midrst_state: got v=%0b rdy=%0b done=%0b want 0/0/0", bus.resp_valid, bus.req_ready, init_done); end
      checks++; if (free_cnt !== (IW+1)'(NP) || ram_write_en !== 1'b1 || ram_write_addr !== '0) begin errors++; $display("FAIL midrst_init: got cnt=%0d we=%0b a=%0d want %0d/1/0", free_cnt, ram_write_en, ram_write_addr, NP); end
      run_init(n, b);
      checks++; if (n != NW || b != 0 || !init_done) begin errors++; $display("FAIL midrst_reinit: got %0d writes %0d bad want %0d/0", n, b, NW); end
      model_alloc(e, ef); do_op(1'b0, 0);
      checks++; if (ob_idx !== IW'(e) || ob_lat != 4 || free_cnt !== (IW+1)'(mfree)) begin errors++; $display("FAIL midrst_alloc: got %0d lat %0d cnt %0d want %0d/4/%0d", ob_idx, ob_lat, free_cnt, e, mfree); end
   endtask

   initial begin
      model_clear();
      test_reset();
      test_back_to_back();
      test_scan_pair();
      test_free();
      test_random();
      test_full();
      test_stall();
      test_reset_midop();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end
endmodule
